// File: rtl/ahb_des_slave_ctrl.sv
// AHB-Lite slave front end for a Triple-DES datapath.
// Provides key/control/status registers, an input block FIFO towards the core
// and a one-entry result buffer read back over the bus.
// Optional build macro DES_SLAVE_IRQ_EN adds CTRL.irq_en and a registered irq output.
module ahb_des_slave_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int NUM_KEYS   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     HSEL,
  input  logic [ADDR_W-1:0]        HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [2:0]               HBURST,
  input  logic [63:0]              HWDATA,
  input  logic                     HREADY,
  output logic                     HREADYOUT,
  output logic                     HRESP,
  output logic [63:0]              HRDATA,
  output logic                     core_valid,
  input  logic                     core_ready,
  output logic [63:0]              core_data,
  output logic                     core_mode,
  output logic [NUM_KEYS*64-1:0]   core_keys,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [63:0]              res_data
`ifdef DES_SLAVE_IRQ_EN
  ,
  output logic                     irq
`endif
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int KIDX_W = ADDR_W - 3;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DATA = 2'd1, ST_ERR = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   dp_addr_q, dp_addr_d;
  logic                dp_write_q, dp_write_d;
  logic                dp_size_ok_q, dp_size_ok_d;
  logic                mode_q, mode_d;
  logic                irq_en_q, irq_en_d;
  logic                irq_q, irq_d;
  logic [63:0]         keys_q [NUM_KEYS];
  logic [63:0]         keys_d [NUM_KEYS];
  logic [63:0]         fifo_mem_q [FIFO_DEPTH];
  logic [63:0]         fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                result_valid_q, result_valid_d;
  logic [63:0]         result_q, result_d;

  logic [KIDX_W-1:0]   blk_s, key_off_s;
  logic                is_ctrl_s, is_stat_s, is_key_s, is_din_s, is_dout_s, mapped_s;
  logic                err_s, stall_s, commit_s, wr_commit_s, rd_commit_s;
  logic                push_s, pop_s, rpop_s, flush_s, full_s, empty_s, in_data_s;
  logic                irq_en_rd_s;
  logic [63:0]         key_rd_s;
  logic                unused_s;

  assign unused_s = ^{HTRANS[0], HBURST};

  // Decode the captured data-phase transfer and derive FIFO/commit qualifiers.
  always_comb begin
    blk_s     = dp_addr_q[ADDR_W-1:3];
    key_off_s = blk_s - KIDX_W'(2);
    is_ctrl_s = (blk_s == KIDX_W'(0));
    is_stat_s = (blk_s == KIDX_W'(1));
    is_key_s  = (blk_s >= KIDX_W'(2)) && (key_off_s < KIDX_W'(NUM_KEYS));
    is_din_s  = (blk_s == KIDX_W'(8));
    is_dout_s = (blk_s == KIDX_W'(9));
    mapped_s  = (dp_addr_q[2:0] == 3'b000) &&
                (is_ctrl_s || is_stat_s || is_key_s || is_din_s || is_dout_s);
    full_s    = (count_q == CNT_W'(FIFO_DEPTH));
    empty_s   = (count_q == CNT_W'(0));
    pop_s     = !empty_s && core_ready;
    in_data_s = (state_q == ST_DATA);
    err_s     = !dp_size_ok_q || !mapped_s ||
                (dp_write_q && (is_stat_s || is_dout_s)) ||
                (!dp_write_q && is_din_s) ||
                (!dp_write_q && is_dout_s && !result_valid_q);
    stall_s     = in_data_s && !err_s && dp_write_q && is_din_s && full_s && !pop_s;
    commit_s    = in_data_s && !err_s && !stall_s;
    wr_commit_s = commit_s && dp_write_q;
    rd_commit_s = commit_s && !dp_write_q;
    push_s      = wr_commit_s && is_din_s;
    rpop_s      = rd_commit_s && is_dout_s;
    flush_s     = wr_commit_s && is_ctrl_s && HWDATA[1];
    key_rd_s    = 64'h0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      key_rd_s = (key_off_s == KIDX_W'(k)) ? keys_q[k] : key_rd_s;
    end
  end

`ifdef DES_SLAVE_IRQ_EN
  assign irq_en_rd_s = irq_en_q;
  assign irq         = irq_q;
`else
  assign irq_en_rd_s = 1'b0;
`endif

  // Bus response and read-data mux; HREADYOUT must see a same-cycle core pop.
  always_comb begin
    case (state_q)
      ST_IDLE: begin HREADYOUT = 1'b1;              HRESP = 1'b0;  end
      ST_DATA: begin HREADYOUT = !(err_s || stall_s); HRESP = err_s; end
      ST_ERR:  begin HREADYOUT = 1'b1;              HRESP = 1'b1;  end
      default: begin HREADYOUT = 1'b1;              HRESP = 1'b0;  end
    endcase
    if (rd_commit_s) begin
      if (is_ctrl_s)      HRDATA = {61'h0, irq_en_rd_s, 1'b0, mode_q};
      else if (is_stat_s) HRDATA = {48'h0, 8'(count_q), 5'h0, result_valid_q, full_s, empty_s};
      else if (is_dout_s) HRDATA = result_q;
      else if (is_key_s)  HRDATA = key_rd_s;
      else                HRDATA = 64'h0;
    end else begin
      HRDATA = 64'h0;
    end
  end

  // Core-facing outputs driven straight from state.
  always_comb begin
    core_valid = !empty_s;
    core_data  = fifo_mem_q[rd_ptr_q];
    core_mode  = mode_q;
    res_ready  = !result_valid_q;
    core_keys  = {(NUM_KEYS*64){1'b0}};
    for (int k = 0; k < NUM_KEYS; k++) begin
      core_keys[64*k +: 64] = keys_q[k];
    end
  end

  // Next-state: transfer FSM, registers, FIFO and result buffer.
  always_comb begin
    dp_addr_d    = dp_addr_q;
    dp_write_d   = dp_write_q;
    dp_size_ok_d = dp_size_ok_q;
    if (in_data_s && err_s) begin
      state_d = ST_ERR;
    end else if (stall_s) begin
      state_d = ST_DATA;
    end else if (HSEL && HREADY && HTRANS[1]) begin
      state_d      = ST_DATA;
      dp_addr_d    = HADDR;
      dp_write_d   = HWRITE;
      dp_size_ok_d = (HSIZE == 3'b011);
    end else begin
      state_d = ST_IDLE;
    end

    mode_d   = (wr_commit_s && is_ctrl_s) ? HWDATA[0] : mode_q;
`ifdef DES_SLAVE_IRQ_EN
    irq_en_d = (wr_commit_s && is_ctrl_s) ? HWDATA[2] : irq_en_q;
`else
    irq_en_d = 1'b0;
`endif
    irq_d    = result_valid_q && irq_en_q;

    keys_d = keys_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      keys_d[k] = (wr_commit_s && is_key_s && key_off_s == KIDX_W'(k)) ? HWDATA : keys_q[k];
    end

    fifo_mem_d = fifo_mem_q;
    if (push_s) fifo_mem_d[wr_ptr_q] = HWDATA;
    else        fifo_mem_d[wr_ptr_q] = fifo_mem_q[wr_ptr_q];

    // Flush wins over everything, including a pop the core makes this cycle.
    if (flush_s) begin
      wr_ptr_d = PTR_W'(0);
      rd_ptr_d = PTR_W'(0);
      count_d  = CNT_W'(0);
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
      count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    result_d = result_q;
    if (flush_s || rpop_s) begin
      result_valid_d = 1'b0;
    end else if (res_valid && !result_valid_q) begin
      result_valid_d = 1'b1;
      result_d       = res_data;
    end else begin
      result_valid_d = result_valid_q;
    end
  end

  // All state flops; reset aborts any transfer in progress.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q        <= ST_IDLE;
      dp_addr_q      <= {ADDR_W{1'b0}};
      dp_write_q     <= 1'b0;
      dp_size_ok_q   <= 1'b0;
      mode_q         <= 1'b0;
      irq_en_q       <= 1'b0;
      irq_q          <= 1'b0;
      wr_ptr_q       <= PTR_W'(0);
      rd_ptr_q       <= PTR_W'(0);
      count_q        <= CNT_W'(0);
      result_valid_q <= 1'b0;
      result_q       <= 64'h0;
      for (int k = 0; k < NUM_KEYS; k++) keys_q[k] <= 64'h0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= 64'h0;
    end else begin
      state_q        <= state_d;
      dp_addr_q      <= dp_addr_d;
      dp_write_q     <= dp_write_d;
      dp_size_ok_q   <= dp_size_ok_d;
      mode_q         <= mode_d;
      irq_en_q       <= irq_en_d;
      irq_q          <= irq_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      keys_q         <= keys_d;
      fifo_mem_q     <= fifo_mem_d;
    end
  end

endmodule

// File: tb/tb_ahb_des_slave_ctrl.sv
// Directed self-checking bench for ahb_des_slave_ctrl (default parameters).
module tb_ahb_des_slave_ctrl;

  logic         clk = 1'b0;
  logic         hreset_n;
  logic         hsel;
  logic [11:0]  haddr;
  logic [1:0]   htrans;
  logic         hwrite;
  logic [2:0]   hsize;
  logic [2:0]   hburst;
  logic [63:0]  hwdata;
  logic         hready;
  logic         hreadyout;
  logic         hresp;
  logic [63:0]  hrdata;
  logic         core_valid;
  logic         core_ready;
  logic [63:0]  core_data;
  logic         core_mode;
  logic [191:0] core_keys;
  logic         res_valid;
  logic         res_ready;
  logic [63:0]  res_data;
`ifdef DES_SLAVE_IRQ_EN
  logic         irq;
`endif

  int passed = 0;
  int total  = 0;
  int failed = 0;

  localparam logic [63:0] K0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K1 = 64'h1111111111111111;
  localparam logic [63:0] K2 = 64'h2222222222222222;
  localparam logic [63:0] RES = 64'hDEADBEEFCAFEF00D;

  assign hready = hreadyout;

  always #5 clk = ~clk;

  ahb_des_slave_ctrl dut (
    .HCLK(clk), .HRESET(hreset_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata),
    .core_valid(core_valid), .core_ready(core_ready), .core_data(core_data),
    .core_mode(core_mode), .core_keys(core_keys),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
`ifdef DES_SLAVE_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic w, input logic [11:0] a, input logic [2:0] s);
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = s;
    @(posedge clk);
  endtask

  task automatic data_phase(input logic [63:0] wd, output logic [63:0] rd,
                            output logic resp, output logic first_resp, output int waits);
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    #1;
    first_resp = hresp;
    waits = 0;
    while (!hreadyout && waits < 32) begin
      @(negedge clk); #1;
      waits++;
    end
    rd = hrdata;
    resp = hresp;
  endtask

  task automatic wr_ok(input string tag, input logic [11:0] a, input logic [63:0] d);
    logic [63:0] rd; logic resp, fr; int waits;
    addr_phase(1'b1, a, 3'b011);
    data_phase(d, rd, resp, fr, waits);
    check({tag, " okay"}, {31'h0, resp, waits}, 64'h0);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [63:0] exp);
    logic [63:0] rd; logic resp, fr; int waits;
    addr_phase(1'b0, a, 3'b011);
    data_phase(64'h0, rd, resp, fr, waits);
    check({tag, " okay"}, {31'h0, resp, waits}, 64'h0);
    check({tag, " data"}, rd, exp);
  endtask

  task automatic err_chk(input string tag, input logic w, input logic [11:0] a, input logic [2:0] s);
    logic [63:0] rd; logic resp, fr; int waits;
    addr_phase(w, a, s);
    data_phase(64'hFFFF_FFFF_FFFF_FFFF, rd, resp, fr, waits);
    check({tag, " err"}, {fr, resp, 30'h0, waits}, {1'b1, 1'b1, 30'h0, 32'd1});
    check({tag, " hrdata"}, rd, 64'h0);
  endtask

  task automatic pulse_result(input logic [63:0] d);
    @(negedge clk); res_valid = 1'b1; res_data = d;
    @(negedge clk); res_valid = 1'b0; #1;
  endtask

  initial begin
    logic [63:0] blk [5];
    for (int i = 0; i < 5; i++) blk[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    hreset_n = 1'b0; hsel = 1'b0; haddr = 12'h000; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b011; hburst = 3'b000; hwdata = 64'h0; core_ready = 1'b0;
    res_valid = 1'b0; res_data = 64'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); hreset_n = 1'b1; #1;

    // Reset state
    check("rst hreadyout", 64'(hreadyout), 64'h1);
    check("rst hresp", 64'(hresp), 64'h0);
    check("rst hrdata", hrdata, 64'h0);
    check("rst core_valid", 64'(core_valid), 64'h0);
    check("rst res_ready", 64'(res_ready), 64'h1);
    check("rst keys", 64'(|core_keys), 64'h0);
    rd_chk("rst status", 12'h008, 64'h1);

    // Key registers
    wr_ok("wr key0", 12'h010, K0);
    wr_ok("wr key1", 12'h018, K1);
    wr_ok("wr key2", 12'h020, K2);
    rd_chk("rd key0", 12'h010, K0);
    rd_chk("rd key1", 12'h018, K1);
    rd_chk("rd key2", 12'h020, K2);
    check("core_keys k0", core_keys[63:0], K0);
    check("core_keys k1", core_keys[127:64], K1);
    check("core_keys k2", core_keys[191:128], K2);

    // FIFO fill, back-pressure, push+pop at full
    for (int i = 0; i < 4; i++) wr_ok("din fill", 12'h040, blk[i]);
    addr_phase(1'b1, 12'h040, 3'b011);
    @(negedge clk); hsel = 1'b0; htrans = 2'b00; hwdata = blk[4]; #1;
    check("din stall 1", 64'(hreadyout), 64'h0);
    @(negedge clk); #1;
    check("din stall 2", 64'(hreadyout), 64'h0);
    core_ready = 1'b1; #1;
    check("din release", 64'(hreadyout), 64'h1);
    check("core_data head", core_data, blk[0]);
    @(negedge clk); core_ready = 1'b0; #1;
    check("core_data next", core_data, blk[1]);
    rd_chk("status full", 12'h008, 64'h402);

    // Result buffer
    err_chk("dout empty", 1'b0, 12'h048, 3'b011);
    pulse_result(RES);
    check("res_ready full", 64'(res_ready), 64'h0);
    rd_chk("status res", 12'h008, 64'h406);
    rd_chk("dout", 12'h048, RES);
    rd_chk("status popped", 12'h008, 64'h402);
    check("res_ready empty", 64'(res_ready), 64'h1);

    // Error cases leave state untouched
    err_chk("key0 hsize", 1'b1, 12'h010, 3'b010);
    err_chk("status wr", 1'b1, 12'h008, 3'b011);
    err_chk("unmapped", 1'b0, 12'h080, 3'b011);
    err_chk("din rd", 1'b0, 12'h040, 3'b011);
    rd_chk("key0 kept", 12'h010, K0);

    // Drain, refill three, flush
    @(negedge clk); core_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); core_ready = 1'b0; #1;
    check("drained", 64'(core_valid), 64'h0);
    for (int i = 0; i < 3; i++) wr_ok("din three", 12'h040, blk[i]);
    rd_chk("status three", 12'h008, 64'h300);
    wr_ok("ctrl flush", 12'h000, 64'h3);
    rd_chk("status flushed", 12'h008, 64'h1);
    check("flush core_valid", 64'(core_valid), 64'h0);
    check("flush mode", 64'(core_mode), 64'h1);
    rd_chk("ctrl rd", 12'h000, 64'h1);

`ifdef DES_SLAVE_IRQ_EN
    wr_ok("ctrl irq_en", 12'h000, 64'h4);
    rd_chk("ctrl irq rd", 12'h000, 64'h4);
    @(negedge clk); res_valid = 1'b1; res_data = 64'h55;
    @(negedge clk); res_valid = 1'b0; #1;
    check("irq pre", 64'(irq), 64'h0);
    @(negedge clk); #1;
    check("irq set", 64'(irq), 64'h1);
    rd_chk("irq dout", 12'h048, 64'h55);
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    check("irq clr", 64'(irq), 64'h0);
`else
    wr_ok("ctrl bit2", 12'h000, 64'h4);
    rd_chk("ctrl bit2 rd", 12'h000, 64'h0);
`endif

    // Reset aborts a stalled DATA_IN transfer
    for (int i = 0; i < 4; i++) wr_ok("din refill", 12'h040, blk[i]);
    addr_phase(1'b1, 12'h040, 3'b011);
    @(negedge clk); hsel = 1'b0; htrans = 2'b00; hwdata = blk[4]; #1;
    check("pre-rst stall", 64'(hreadyout), 64'h0);
    hreset_n = 1'b0; #1;
    check("rst abort ready", 64'(hreadyout), 64'h1);
    check("rst abort valid", 64'(core_valid), 64'h0);
    check("rst abort keys", 64'(|core_keys), 64'h0);
    @(negedge clk); hreset_n = 1'b1;
    rd_chk("post-rst status", 12'h008, 64'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
